seq_arith_unit: RTL

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

---
 rtl/seq_arith_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: sequential add/sub/mul/div/mod unit.
// Handshake via in_valid/in_ready and out_valid/out_ready.
module seq_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   inputA,
  input  logic [WIDTH-1:0]   inputB,
  input  logic [3:0]         op_code,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] R,
  output logic               error,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDSUB = 3'd1;
  localparam logic [2:0] MUL    = 3'd2;
  localparam logic [2:0] DIV    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0001;

  logic [2:0]         r_state;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_R;
  logic               r_err;

  logic               w_accept;
  logic [2:0]         w_first;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_dif;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_fin_R;
  logic               w_fin_err;
  logic               w_is_dm;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign R         = r_R;
  assign error     = r_err;
  assign w_accept  = in_valid && in_ready;
  assign w_is_dm   = (op_code == OP_DIV) || (op_code == OP_MOD);

  assign w_sum = r_a[WIDTH-1:0] + r_b;
  assign w_dif = r_a[WIDTH-1:0] - r_b;
  assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                     (w_dif[WIDTH-1] != r_a[WIDTH-1]);

  assign w_rem_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_b};
  assign w_fits   = (w_rem_sh >= {1'b0, r_b});

  // Single-cycle ops (incl. div-by-zero and illegal) finish via ADDSUB,
  // which gives every short command the same one-cycle latency.
  always_comb begin
    w_first = ADDSUB;
    unique case (1'b1)
      (op_code == OP_MUL):          w_first = MUL;
      (w_is_dm && inputB != '0):    w_first = DIV;
      default:                      w_first = ADDSUB;
    endcase
  end

  always_comb begin
    w_fin_R   = '0;
    w_fin_err = 1'b1;
    unique case (1'b1)
      (r_op == OP_ADD): begin
        w_fin_R   = {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
        w_fin_err = w_add_ovf;
      end
      (r_op == OP_SUB): begin
        w_fin_R   = {{WIDTH{w_dif[WIDTH-1]}}, w_dif};
        w_fin_err = w_sub_ovf;
      end
      (r_op == OP_DIV || r_op == OP_MOD): begin
        w_fin_R   = '1;
        w_fin_err = 1'b1;
      end
      default: begin
        w_fin_R   = '0;
        w_fin_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_R     <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= w_first;
            r_op    <= op_code;
            r_a     <= {{WIDTH{1'b0}}, inputA};
            r_b     <= inputB;
            r_acc   <= '0;
            r_q     <= inputA;
            r_rem   <= '0;
            r_cnt   <= CNT_INIT;
          end
        end
        ADDSUB: begin
          r_R     <= w_fin_R;
          r_err   <= w_fin_err;
          r_state <= DONE;
        end
        MUL: begin
          if (r_cnt == '0) begin
            r_R     <= r_acc;
            r_err   <= 1'b0;
            r_state <= DONE;
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DIV: begin
          if (r_cnt == '0) begin
            r_R <= (r_op == OP_MOD) ?
                   {{WIDTH{1'b0}}, r_rem[WIDTH-1:0]} :
                   {{WIDTH{1'b0}}, r_q};
            r_err   <= 1'b0;
            r_state <= DONE;
          end else begin
            r_rem <= w_fits ? w_trial : w_rem_sh;
            r_q   <= {r_q[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
